// File: rtl/switch_debounce.sv
// switch_debounce
//   Four independent push-button debouncers. Each channel synchronizes its raw
//   input through two flops, then accepts a new level only after it has differed
//   from the debounced value for DEBOUNCE_LIMIT consecutive counting clocks.
//   A glitch shorter than that is discarded with no partial credit.
//
//   Optional feature: define DEBOUNCE_TOGGLE_EN to add o_Toggle.
//
// Ports
//   i_Clk                    system clock, all state on rising edge
//   i_Reset                  synchronous active-high reset
//   i_Switch_1..i_Switch_4   raw asynchronous button levels, 1 = pressed
//   o_Switch_1..o_Switch_4   registered debounced levels
//   o_Press[3:0]             one-cycle pulse on debounced 0->1, bit n-1 = channel n
//   o_Release[3:0]           one-cycle pulse on debounced 1->0, bit n-1 = channel n
//   o_Toggle[3:0]            (DEBOUNCE_TOGGLE_EN only) inverts on each press pulse
module switch_debounce #(
    parameter int unsigned DEBOUNCE_LIMIT = 250000
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Switch_1,
    input  logic       i_Switch_2,
    input  logic       i_Switch_3,
    input  logic       i_Switch_4,
    output logic       o_Switch_1,
    output logic       o_Switch_2,
    output logic       o_Switch_3,
    output logic       o_Switch_4,
    output logic [3:0] o_Press,
    output logic [3:0] o_Release
`ifdef DEBOUNCE_TOGGLE_EN
    ,
    output logic [3:0] o_Toggle
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    typedef enum logic {STABLE, COUNTING} state_t;

    logic [3:0]       raw;
    logic [3:0]       sync1, sync2;
    logic [3:0]       deb, deb_next;
    logic [3:0]       press_next, release_next;
    logic [3:0]       load;
    state_t           state      [4];
    state_t           state_next [4];
    logic [CNT_W-1:0] cnt        [4];
    logic [CNT_W-1:0] cnt_next   [4];

    assign raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

    // State register: synchronizers, FSM state, counters and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            o_Press   <= '0;
            o_Release <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            sync1     <= raw;
            sync2     <= sync1;
            deb       <= deb_next;
            o_Press   <= press_next;
            o_Release <= release_next;
            for (int unsigned i = 0; i < 4; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
        end
    end

    // Next-state logic. A mismatch first moves STABLE to COUNTING with the
    // counter still at 0; the load happens on the edge where the counter has
    // reached its last value, so the counter never wraps.
    always_comb begin
        load = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            case (state[i])
                STABLE: begin
                    cnt_next[i] = '0;
                    if (sync2[i] != deb[i]) state_next[i] = COUNTING;
                end
                COUNTING: begin
                    if (sync2[i] == deb[i]) begin
                        state_next[i] = STABLE;
                        cnt_next[i]   = '0;
                    end else if (cnt[i] == CNT_LAST) begin
                        load[i]       = 1'b1;
                        state_next[i] = STABLE;
                        cnt_next[i]   = '0;
                    end else begin
                        cnt_next[i] = cnt[i] + 1'b1;
                    end
                end
                default: begin
                    state_next[i] = STABLE;
                    cnt_next[i]   = '0;
                end
            endcase
        end
    end

    // Output logic: pulses are registered together with the debounced level,
    // so they are high exactly in the cycle the level has just changed.
    always_comb begin
        deb_next     = (deb & ~load) | (sync2 & load);
        press_next   = load & sync2;
        release_next = load & ~sync2;
    end

    assign o_Switch_1 = deb[0];
    assign o_Switch_2 = deb[1];
    assign o_Switch_3 = deb[2];
    assign o_Switch_4 = deb[3];

`ifdef DEBOUNCE_TOGGLE_EN
    logic [3:0] toggle;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) toggle <= '0;
        else         toggle <= toggle ^ press_next;
    end

    assign o_Toggle = toggle;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce with DEBOUNCE_LIMIT = 4.
// The driver applies directed scenarios followed by randomized hold lengths,
// steps a run-length reference model each cycle and queues the expected
// outputs; the monitor pops one entry per cycle and compares.
module tb_switch_debounce;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw_in = '0;
    logic       sw1, sw2, sw3, sw4;
    logic [3:0] press, rel;
`ifdef DEBOUNCE_TOGGLE_EN
    logic [3:0] tog;
`endif

    always #5 clk = ~clk;

    switch_debounce #(.DEBOUNCE_LIMIT(LIM)) dut (
        .i_Clk      (clk),
        .i_Reset    (rst),
        .i_Switch_1 (sw_in[0]),
        .i_Switch_2 (sw_in[1]),
        .i_Switch_3 (sw_in[2]),
        .i_Switch_4 (sw_in[3]),
        .o_Switch_1 (sw1),
        .o_Switch_2 (sw2),
        .o_Switch_3 (sw3),
        .o_Switch_4 (sw4),
        .o_Press    (press),
        .o_Release  (rel)
`ifdef DEBOUNCE_TOGGLE_EN
        ,
        .o_Toggle   (tog)
`endif
    );

    typedef struct {
        logic [3:0] sw;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] tog;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   armed    = 0;
    bit   done     = 0;

    // Reference model: a level is accepted once it has been seen on the
    // synchronized side for LIM+1 consecutive edges (one edge to notice the
    // mismatch, LIM edges counting). Synchronizer modelled as a 2-deep delay.
    bit [3:0] m_d, m_dl1, m_dl2, m_tog;
    int       m_run[4];

    function automatic exp_t model_step(input bit r, input bit [3:0] raw);
        exp_t e;
        bit [3:0] seen;
        e.press = '0;
        e.rel   = '0;
        if (r) begin
            m_d = '0; m_dl1 = '0; m_dl2 = '0; m_tog = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            seen  = m_dl2;
            m_dl2 = m_dl1;
            m_dl1 = raw;
            for (int i = 0; i < 4; i++) begin
                if (seen[i] != m_d[i]) begin
                    m_run[i]++;
                    if (m_run[i] == LIM + 1) begin
                        m_d[i] = seen[i];
                        if (seen[i]) e.press[i] = 1'b1;
                        else         e.rel[i]   = 1'b1;
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_tog = m_tog ^ e.press;
        end
        e.sw  = m_d;
        e.tog = m_tog;
        return e;
    endfunction

    task automatic drive(input bit r, input bit [3:0] raw, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rst   = r;
            sw_in = raw;
            q.push_back(model_step(r, raw));
            armed = 1;
        end
    endtask

    // Monitor
    initial begin
        exp_t e;
        logic [3:0] sw_all;
        forever begin
            @(posedge clk);
            #1;
            if (armed && !done) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL underflow: DUT cycle with no expected entry at %0t", $time);
                end else begin
                    e = q.pop_front();
                    sw_all = {sw4, sw3, sw2, sw1};
                    if (sw_all !== e.sw) begin
                        failures++;
                        $display("FAIL o_Switch @%0t: got %b want %b", $time, sw_all, e.sw);
                    end
                    checks++;
                    if (press !== e.press) begin
                        failures++;
                        $display("FAIL o_Press @%0t: got %b want %b", $time, press, e.press);
                    end
                    checks++;
                    if (rel !== e.rel) begin
                        failures++;
                        $display("FAIL o_Release @%0t: got %b want %b", $time, rel, e.rel);
                    end
                    checks++;
                    if ((press & rel) !== 4'b0000) begin
                        failures++;
                        $display("FAIL press_and_release @%0t: got %b want 0000", $time, press & rel);
                    end
`ifdef DEBOUNCE_TOGGLE_EN
                    checks++;
                    if (tog !== e.tog) begin
                        failures++;
                        $display("FAIL o_Toggle @%0t: got %b want %b", $time, tog, e.tog);
                    end
`endif
                end
            end
        end
    end

    // Driver
    initial begin
        int          hold[4];
        bit [3:0]    lvl;
        bit          r;
        bit [3:0]    bounce;
        bit [8:0]    pat;

        drive(1'b1, 4'b0000, 3);
        // single clean press and release on channel 1 (twice, for toggle)
        drive(1'b0, 4'b0001, 12);
        drive(1'b0, 4'b0000, 12);
        drive(1'b0, 4'b0001, 12);
        drive(1'b0, 4'b0000, 12);
        // short glitch on channel 2
        drive(1'b0, 4'b0010, 3);
        drive(1'b0, 4'b0000, 12);
        // bounce on channel 3, then steady high
        pat = 9'b111101101;
        for (int i = 0; i < 9; i++) begin
            bounce = {1'b0, pat[i], 2'b00};
            drive(1'b0, bounce, 1);
        end
        drive(1'b0, 4'b0100, 12);
        drive(1'b0, 4'b0000, 12);
        // all channels together
        drive(1'b0, 4'b1111, 12);
        drive(1'b0, 4'b0000, 12);
        // reset in the middle of a count on channel 4
        drive(1'b0, 4'b1000, 4);
        drive(1'b1, 4'b1000, 2);
        drive(1'b0, 4'b1000, 12);
        drive(1'b0, 4'b0000, 12);

        // randomized hold lengths straddling the acceptance threshold
        lvl = '0;
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 2 * LIM + 2);
                end
                hold[i]--;
            end
            r = ($urandom_range(0, 299) == 0);
            drive(r, lvl, 1);
        end

        @(posedge clk);
        #2;
        done = 1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover: got %0d queued entries want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
